// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 demux dispatcher.
package demux_pkg;

    localparam int unsigned NPORTS = 4;
    localparam int unsigned PORT_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // One-hot with port 0 in the leftmost bit, matching the [0:NPORTS-1] buses.
    function automatic logic [0:NPORTS-1] onehot(input logic [PORT_W-1:0] idx);
        logic [0:NPORTS-1] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 4-way rotating priority: first requester after ptr, ptr itself last.
module rr_pick
    import demux_pkg::*;
(
    input  logic [0:NPORTS-1] req,
    input  logic [PORT_W-1:0] ptr,
    output logic [PORT_W-1:0] grant,
    output logic              any
);

    logic [PORT_W-1:0] w_idx;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int i = int'(NPORTS); i > 0; i--) begin
            w_idx = ptr + PORT_W'(i);
            if (req[w_idx]) begin
                grant = w_idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_dispatch.sv
// One-entry dispatch register driving a 1-to-4 demux, directed or round-robin,
// with a saturating stall counter for blocking consumers.
module demux_dispatch
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned STALL_W     = 8,
    parameter int unsigned STALL_LIMIT = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PORT_W-1:0] in_dest,
    output logic [PORT_W-1:0] sel,
    output logic [0:NPORTS-1] out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [0:NPORTS-1] out_ready,
    output logic              stall
);

    localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_acc;
    logic                w_fire;
    logic [PORT_W-1:0]   r_sel;
    logic [PORT_W-1:0]   r_ptr;
    logic [PORT_W-1:0]   w_ptr_eff;
    logic [PORT_W-1:0]   w_rr_grant;
    logic                w_rr_any;
    logic [PORT_W-1:0]   w_new_sel;
    logic [0:NPORTS-1]   r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [STALL_W-1:0]  r_cnt;
    logic                r_stall;

    assign sel       = r_sel;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign stall     = r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Refill in the same cycle as fire keeps throughput at one word per cycle.
    always_comb begin
        w_next_state = r_state;
        w_fire       = (r_state == SEND) && out_ready[r_sel];
        in_ready     = (r_state == IDLE) || w_fire;
        w_acc        = in_valid && in_ready;
        case (r_state)
            IDLE:    if (w_acc) w_next_state = SEND;
            SEND:    if (w_fire && !w_acc) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Round-robin search starts after the port being served this very cycle.
    assign w_ptr_eff = w_fire ? r_sel : r_ptr;

    rr_pick u_rr_pick (
        .req   (out_ready),
        .ptr   (w_ptr_eff),
        .grant (w_rr_grant),
        .any   (w_rr_any)
    );

    always_comb begin
        w_new_sel = in_dest;
        if (mode) w_new_sel = w_rr_any ? w_rr_grant : w_ptr_eff + PORT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_ptr   <= PORT_W'(3);
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            if (w_acc) begin
                r_data  <= in_data;
                r_sel   <= w_new_sel;
                r_valid <= onehot(w_new_sel);
            end else if (w_fire) begin
                r_valid <= '0;
            end
            if (w_fire) r_ptr <= r_sel;
        end
    end

    // Stall counter: counts cycles a held word waits, flag lags by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else begin
            if (w_acc || w_fire)                      r_cnt <= '0;
            else if (r_state == SEND && r_cnt != '1)  r_cnt <= r_cnt + STALL_W'(1);
            r_stall <= (r_cnt >= LIMIT);
        end
    end

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed bench for demux_dispatch: directed/round-robin dispatch, stall flag, reset, held-word stability.
module tb_demux_dispatch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic [1:0] sel;
    logic [0:3] out_valid;
    logic [7:0] out_data;
    logic [0:3] out_ready;
    logic       stall;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0] dests [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
    logic [3:0] ovs   [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0100};
    logic [1:0] rr3   [4] = '{2'd0, 2'd2, 2'd0, 2'd2};

    demux_dispatch #(.DATA_W(8), .STALL_W(8), .STALL_LIMIT(200)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        mode      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; out_ready = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_sel",       32'(sel),       32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_stall",     32'(stall),     32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Directed, all ready, back-to-back
        mode = 1'b0; out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(i); in_dest = dests[i];
            #1 chk("dir_in_ready", 32'(in_ready), 32'h1);
            tick;
            chk("dir_sel",       32'(sel),       32'(dests[i]));
            chk("dir_out_valid", 32'(out_valid), 32'(ovs[i]));
            chk("dir_out_data",  32'(out_data),  32'(8'hA0 + 8'(i)));
        end
        in_valid = 1'b0;
        tick;
        chk("dir_drain", 32'(out_valid), 32'h0);

        // Round-robin, all ready
        do_reset;
        mode = 1'b1; out_ready = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'hB0 + 8'(i);
            tick;
            chk("rr_sel",       32'(sel),       32'(i % 4));
            chk("rr_out_valid", 32'(out_valid), 32'(4'b1000 >> (i % 4)));
            chk("rr_out_data",  32'(out_data),  32'(8'hB0 + 8'(i)));
        end
        in_valid = 1'b0;
        tick;
        chk("rr_drain", 32'(out_valid), 32'h0);

        // Round-robin, only ports 0 and 2 ready
        do_reset;
        mode = 1'b1; out_ready = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
            tick;
            chk("rr1010_sel", 32'(sel), 32'(rr3[i]));
        end
        in_valid = 1'b0;
        tick;
        chk("rr1010_drain", 32'(out_valid), 32'h0);
        out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'hC4;
        tick;
        chk("rr_none_sel",  32'(sel),       32'h3);
        chk("rr_none_ov",   32'(out_valid), 32'(4'b0001));
        in_valid = 1'b0; out_ready = 4'b1110;
        #1 chk("rr_none_hold_ready", 32'(in_ready), 32'h0);
        tick;
        chk("rr_none_hold_sel", 32'(sel),       32'h3);
        chk("rr_none_hold_ov",  32'(out_valid), 32'(4'b0001));
        out_ready = 4'b0001;
        #1 chk("rr_none_fire_ready", 32'(in_ready), 32'h1);
        tick;
        chk("rr_none_done", 32'(out_valid), 32'h0);

        // Stall: port 3 blocked for 210 cycles
        do_reset;
        mode = 1'b0; in_dest = 2'd3; out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'hD7;
        tick;
        in_valid = 1'b0;
        for (int k = 1; k <= 210; k++) begin
            tick;
            chk("stall_flag",     32'(stall),     32'(k >= 201));
            chk("stall_ov",       32'(out_valid), 32'(4'b0001));
            chk("stall_in_ready", 32'(in_ready),  32'h0);
        end
        chk("stall_data", 32'(out_data), 32'hD7);
        out_ready = 4'b0001;
        #1 chk("stall_fire_ready", 32'(in_ready), 32'h1);
        tick;
        chk("stall_fired_ov",   32'(out_valid), 32'h0);
        chk("stall_lag",        32'(stall),     32'h1);
        tick;
        chk("stall_cleared",    32'(stall),     32'h0);

        // Reset while a word is held
        do_reset;
        mode = 1'b0; in_dest = 2'd1; out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h5A;
        tick;
        in_valid = 1'b0;
        chk("mid_ov",   32'(out_valid), 32'(4'b0100));
        chk("mid_data", 32'(out_data),  32'h5A);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov",   32'(out_valid), 32'h0);
        chk("mid_rst_data", 32'(out_data),  32'h0);
        chk("mid_rst_sel",  32'(sel),       32'h0);
        tick;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'h1);
        chk("mid_rel_sel",   32'(sel),      32'h0);
        mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h6B;
        tick;
        chk("mid_rr_sel", 32'(sel),       32'h0);
        chk("mid_rr_ov",  32'(out_valid), 32'(4'b1000));
        in_valid = 1'b0;
        tick;

        // mode / in_dest changes while held
        do_reset;
        mode = 1'b0; in_dest = 2'd2; out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'hE1;
        tick;
        mode = 1'b1; in_dest = 2'd0; in_data = 8'hE2;
        tick;
        chk("hold_sel",  32'(sel),       32'h2);
        chk("hold_ov",   32'(out_valid), 32'(4'b0010));
        chk("hold_data", 32'(out_data),  32'hE1);
        mode = 1'b0; in_dest = 2'd3;
        tick;
        chk("hold_sel2",  32'(sel),      32'h2);
        chk("hold_data2", 32'(out_data), 32'hE1);
        out_ready = 4'b0010;
        #1 chk("hold_fire_ready", 32'(in_ready), 32'h1);
        tick;
        d = out_data;
        chk("next_sel",  32'(sel),       32'h3);
        chk("next_ov",   32'(out_valid), 32'(4'b0001));
        chk("next_data", 32'(d),         32'hE2);
        in_valid = 1'b0; out_ready = 4'b0001;
        tick;
        chk("next_drain", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
